// File: rtl/riscv_hpc_pkg.sv
// Shared definitions for the HPC command controller: opcodes, counter
// indices, FSM state type and default bank geometry.
package riscv_hpc_pkg;

  // Default bank geometry
  localparam int DEF_NUM_CNT = 6;
  localparam int DEF_CNT_W   = 32;

  // Command opcodes; 5..7 are rejected with an error response
  localparam logic [2:0] OP_READ_LIVE = 3'd0;
  localparam logic [2:0] OP_READ_SNAP = 3'd1;
  localparam logic [2:0] OP_SNAPSHOT  = 3'd2;
  localparam logic [2:0] OP_CLEAR     = 3'd3;
  localparam logic [2:0] OP_SET_EN    = 3'd4;

  // Counter index per instruction type
  localparam logic [2:0] IDX_R = 3'd0;
  localparam logic [2:0] IDX_I = 3'd1;
  localparam logic [2:0] IDX_S = 3'd2;
  localparam logic [2:0] IDX_B = 3'd3;
  localparam logic [2:0] IDX_U = 3'd4;
  localparam logic [2:0] IDX_J = 3'd5;

  // Controller FSM: accept in IDLE, act in EXEC, hold response in RESP
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/riscv_hpc_snapshot.sv
// Snapshot register file: captures every counter value on a single strobe
// and serves one entry by index. Out-of-range indices read as zero.
module riscv_hpc_snapshot
  import riscv_hpc_pkg::*;
#(
  parameter int NUM_CNT = DEF_NUM_CNT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     cap_i,
  input  logic [NUM_CNT*CNT_W-1:0] vals_i,
  input  logic [2:0]               rd_idx_i,
  output logic [CNT_W-1:0]         rd_data_o,
  output logic                     valid_o
);

  logic [CNT_W-1:0] snap_q [NUM_CNT];
  logic             valid_q;

  // Capture all counters together so the snapshot is coherent
  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_CNT; k++) snap_q[k] <= '0;
      valid_q <= 1'b0;
    end else if (cap_i) begin
      for (int k = 0; k < NUM_CNT; k++) snap_q[k] <= vals_i[k*CNT_W +: CNT_W];
      valid_q <= 1'b1;
    end
  end

  // Read mux; indices beyond the bank fall through to zero
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (rd_idx_i == 3'(k)) rd_data_o = snap_q[k];
    end
  end

  assign valid_o = valid_q;

endmodule

// File: rtl/riscv_hpc_ctrl.sv
// HPC command controller. One command at a time: latched in IDLE, executed
// in EXEC, response held in RESP until consumed.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid must not depend on ready, and the sender holds its payload
// stable while valid is high and ready is low.
module riscv_hpc_ctrl
  import riscv_hpc_pkg::*;
#(
  parameter int                 NUM_CNT  = DEF_NUM_CNT,
  parameter int                 CNT_W    = DEF_CNT_W,
  parameter logic [NUM_CNT-1:0] RESET_EN = '1
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [2:0]               cmd_op_i,
  input  logic [2:0]               cmd_idx_i,
  input  logic [CNT_W-1:0]         cmd_wdata_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [CNT_W-1:0]         rsp_data_o,
  output logic                     rsp_err_o,
  input  logic [NUM_CNT*CNT_W-1:0] cnt_vals_i,
  output logic [NUM_CNT-1:0]       cnt_en_o,
  output logic [NUM_CNT-1:0]       cnt_clr_o,
  output logic                     snap_valid_o
);

  state_e             state_q, state_d;
  logic [2:0]         op_q, idx_q;
  logic [NUM_CNT-1:0] mask_q;
  logic [NUM_CNT-1:0] en_q;
  logic [CNT_W-1:0]   rsp_data_q;
  logic               rsp_err_q;

  logic               in_exec;
  logic               accept;
  logic               idx_ok;
  logic [CNT_W-1:0]   live_sel;
  logic [CNT_W-1:0]   snap_sel;
  logic               snap_valid;
  logic               snap_cap;
  logic [CNT_W-1:0]   exec_data;
  logic               exec_err;

  // Upper operand bits carry no meaning for a bank this size
  logic unused_wdata;
  assign unused_wdata = ^cmd_wdata_i[CNT_W-1:NUM_CNT];

  assign in_exec = (state_q == ST_EXEC);
  assign accept  = cmd_valid_i && cmd_ready_o;
  assign idx_ok  = ({1'b0, idx_q} < 4'(NUM_CNT));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; the clear strobe exists only in a non-reset EXEC cycle
  always_comb begin
    cmd_ready_o = (state_q == ST_IDLE);
    rsp_valid_o = (state_q == ST_RESP);
    cnt_clr_o   = '0;
    if (in_exec && (op_q == OP_CLEAR) && !rst_i) cnt_clr_o = mask_q;
  end

  // Latch the command on acceptance; held untouched until the next one
  always_ff @(posedge clk) begin
    if (rst_i) begin
      op_q   <= '0;
      idx_q  <= '0;
      mask_q <= '0;
    end else if (accept) begin
      op_q   <= cmd_op_i;
      idx_q  <= cmd_idx_i;
      mask_q <= cmd_wdata_i[NUM_CNT-1:0];
    end
  end

  // Live counter select; out-of-range indices are caught by idx_ok
  always_comb begin
    live_sel = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (idx_q == 3'(k)) live_sel = cnt_vals_i[k*CNT_W +: CNT_W];
    end
  end

  riscv_hpc_snapshot #(
    .NUM_CNT (NUM_CNT),
    .CNT_W   (CNT_W)
  ) u_snapshot (
    .clk       (clk),
    .rst_i     (rst_i),
    .cap_i     (snap_cap),
    .vals_i    (cnt_vals_i),
    .rd_idx_i  (idx_q),
    .rd_data_o (snap_sel),
    .valid_o   (snap_valid)
  );

  // Per-opcode result and side-effect decode for the EXEC cycle
  always_comb begin
    exec_data = '0;
    exec_err  = 1'b0;
    snap_cap  = 1'b0;
    case (op_q)
      OP_READ_LIVE: begin
        if (idx_ok) exec_data = live_sel;
        else        exec_err  = 1'b1;
      end
      OP_READ_SNAP: begin
        if (idx_ok && snap_valid) exec_data = snap_sel;
        else                      exec_err  = 1'b1;
      end
      OP_SNAPSHOT: snap_cap  = in_exec && !rst_i;
      OP_CLEAR:    exec_data = CNT_W'(mask_q);
      OP_SET_EN:   exec_data = CNT_W'(en_q);
      default:     exec_err  = 1'b1;
    endcase
  end

  // Count-enable register, rewritten at the end of a SET_EN EXEC cycle
  always_ff @(posedge clk) begin
    if (rst_i)                               en_q <= RESET_EN;
    else if (in_exec && (op_q == OP_SET_EN)) en_q <= mask_q;
  end

  // Response register; loaded in EXEC and frozen through RESP
  always_ff @(posedge clk) begin
    if (rst_i) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (in_exec) begin
      rsp_data_q <= exec_data;
      rsp_err_q  <= exec_err;
    end
  end

  assign rsp_data_o   = rsp_data_q;
  assign rsp_err_o    = rsp_err_q;
  assign cnt_en_o     = en_q;
  assign snap_valid_o = snap_valid;

endmodule

// File: tb/tb_riscv_hpc_ctrl.sv
// Bench for riscv_hpc_ctrl: directed cases followed by random commands,
// responses checked by an independent monitor against a reference model.
module tb_riscv_hpc_ctrl;
  localparam int NUM = 6;
  localparam int W   = 32;
  localparam logic [NUM-1:0] ALL_EN = '1;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_i;
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [2:0]       cmd_op_i;
  logic [2:0]       cmd_idx_i;
  logic [W-1:0]     cmd_wdata_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [W-1:0]     rsp_data_o;
  logic             rsp_err_o;
  logic [NUM*W-1:0] cnt_vals_i;
  logic [NUM-1:0]   cnt_en_o;
  logic [NUM-1:0]   cnt_clr_o;
  logic             snap_valid_o;

  always #5 clk = ~clk;

  riscv_hpc_ctrl dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_op_i     (cmd_op_i),
    .cmd_idx_i    (cmd_idx_i),
    .cmd_wdata_i  (cmd_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_data_o   (rsp_data_o),
    .rsp_err_o    (rsp_err_o),
    .cnt_vals_i   (cnt_vals_i),
    .cnt_en_o     (cnt_en_o),
    .cnt_clr_o    (cnt_clr_o),
    .snap_valid_o (snap_valid_o)
  );

  // Live counter values presented to the DUT
  logic [W-1:0] cur_vals [NUM];
  always_comb begin
    cnt_vals_i = '0;
    for (int k = 0; k < NUM; k++) cnt_vals_i[k*W +: W] = cur_vals[k];
  end

  // ---------------- scoreboard state ----------------
  logic [W:0] exp_q [$];   // {err, data}
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [NUM-1:0] m_en;
  logic [W-1:0]   m_snap [NUM];
  logic           m_snap_valid;

  task automatic model_reset();
    m_en = ALL_EN;
    for (int k = 0; k < NUM; k++) m_snap[k] = '0;
    m_snap_valid = 1'b0;
  endtask

  // Apply one command to the abstract bank state; return {err,data} and clear mask
  task automatic model_cmd(input logic [2:0] op, input logic [2:0] idx, input logic [W-1:0] wd,
                           output logic [W:0] rsp, output logic [NUM-1:0] clr);
    logic [NUM-1:0] m;
    int i;
    m   = wd[NUM-1:0];
    i   = int'(idx);
    rsp = {1'b1, {W{1'b0}}};
    clr = '0;
    case (op)
      3'd0: if (i < NUM) rsp = {1'b0, cur_vals[i]};
      3'd1: if (i < NUM && m_snap_valid) rsp = {1'b0, m_snap[i]};
      3'd2: begin
        for (int k = 0; k < NUM; k++) m_snap[k] = cur_vals[k];
        m_snap_valid = 1'b1;
        rsp = '0;
      end
      3'd3: begin
        clr = m;
        rsp = {1'b0, W'(m)};
      end
      3'd4: begin
        rsp  = {1'b0, W'(m_en)};
        m_en = m;
      end
      default: rsp = {1'b1, {W{1'b0}}};
    endcase
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic       seen;
    logic [W:0] held;
    logic [W:0] exp;
    seen = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rsp_valid_o === 1'b1) begin
        if (!seen) begin
          check("exp_available", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("rsp_data", 64'(rsp_data_o), 64'(exp[W-1:0]));
            check("rsp_err", 64'(rsp_err_o), 64'(exp[W]));
          end
          held = {rsp_err_o, rsp_data_o};
          seen = 1'b1;
        end else begin
          check("rsp_stable", 64'({rsp_err_o, rsp_data_o}), 64'(held));
        end
        if (rsp_ready_i || rst_i) seen = 1'b0;
      end else begin
        seen = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle
  task automatic do_cmd(input logic [2:0] op, input logic [2:0] idx, input logic [W-1:0] wd,
                        input int stall, input bit rst_in_resp);
    logic [W:0]     rsp;
    logic [NUM-1:0] clr, old_en, new_en;
    int budget;
    old_en = m_en;
    model_cmd(op, idx, wd, rsp, clr);
    new_en = m_en;
    exp_q.push_back(rsp);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_idx_i   = idx;
    cmd_wdata_i = wd;
    budget = 20;
    while (cmd_ready_o !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("accept_wait", 64'(budget > 0), 64'd1);
    if (budget == 0) begin
      cmd_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    check("exec_no_rsp", 64'(rsp_valid_o), 64'd0);
    check("exec_clr", 64'(cnt_clr_o), 64'(clr));
    check("exec_en_old", 64'(cnt_en_o), 64'(old_en));
    @(negedge clk);
    check("resp_valid", 64'(rsp_valid_o), 64'd1);
    check("resp_cmd_ready", 64'(cmd_ready_o), 64'd0);
    check("resp_en_new", 64'(cnt_en_o), 64'(new_en));
    check("resp_clr_quiet", 64'(cnt_clr_o), 64'd0);
    check("resp_snap_valid", 64'(snap_valid_o), 64'(m_snap_valid));
    for (int s = 0; s < stall; s++) begin
      cmd_valid_i = 1'b1;
      cmd_op_i    = 3'($urandom_range(0, 7));
      cmd_idx_i   = 3'($urandom_range(0, 7));
      cmd_wdata_i = $urandom;
      @(negedge clk);
      check("stall_cmd_ready", 64'(cmd_ready_o), 64'd0);
      check("stall_rsp_valid", 64'(rsp_valid_o), 64'd1);
    end
    cmd_valid_i = 1'b0;
    if (rst_in_resp) begin
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      model_reset();
      check("rstresp_valid", 64'(rsp_valid_o), 64'd0);
      check("rstresp_en", 64'(cnt_en_o), 64'(ALL_EN));
      check("rstresp_ready", 64'(cmd_ready_o), 64'd1);
      check("rstresp_data", 64'({rsp_err_o, rsp_data_o}), 64'd0);
      check("rstresp_snap", 64'(snap_valid_o), 64'd0);
    end else begin
      rsp_ready_i = 1'b1;
      @(negedge clk);
      rsp_ready_i = 1'b0;
      check("back_idle", 64'(cmd_ready_o), 64'd1);
      check("idle_no_rsp", 64'(rsp_valid_o), 64'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0] r_op, r_idx;
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_op_i    = '0;
    cmd_idx_i   = '0;
    cmd_wdata_i = '0;
    rsp_ready_i = 1'b0;
    for (int k = 0; k < NUM; k++) cur_vals[k] = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    check("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_rsp", 64'({rsp_err_o, rsp_data_o}), 64'd0);
    check("rst_en", 64'(cnt_en_o), 64'(ALL_EN));
    check("rst_clr", 64'(cnt_clr_o), 64'd0);
    check("rst_snap_valid", 64'(snap_valid_o), 64'd0);

    // Directed cases
    cur_vals[2] = 32'h0000_0015;
    do_cmd(3'd0, 3'd2, '0, 0, 1'b0);            // READ_LIVE idx 2 -> 0x15
    do_cmd(3'd3, 3'd0, 32'hFFFF_FF05, 0, 1'b0); // CLEAR 0x05, upper bits ignored
    do_cmd(3'd1, 3'd0, '0, 0, 1'b0);            // READ_SNAP before any capture -> err
    do_cmd(3'd4, 3'd0, 32'h0, 0, 1'b0);         // SET_EN 0 -> prev 0x3F
    do_cmd(3'd4, 3'd0, 32'h3F, 0, 1'b0);        // SET_EN 0x3F -> prev 0
    do_cmd(3'd4, 3'd0, 32'h3F, 0, 1'b0);        // unchanged mask, legal
    do_cmd(3'd3, 3'd0, 32'h0, 0, 1'b0);         // zero clear mask, legal
    do_cmd(3'd0, 3'd6, '0, 0, 1'b0);            // index out of range
    do_cmd(3'd1, 3'd7, '0, 0, 1'b0);            // index out of range
    do_cmd(3'd7, 3'd0, 32'h3F, 0, 1'b0);        // illegal opcode, no side effects
    do_cmd(3'd5, 3'd0, 32'h0, 0, 1'b0);         // illegal opcode, no side effects
    for (int k = 0; k < NUM; k++) cur_vals[k] = W'(k + 1);
    do_cmd(3'd2, 3'd0, '0, 0, 1'b0);            // SNAPSHOT {1..6}
    for (int k = 0; k < NUM; k++) cur_vals[k] = 32'hFF;
    do_cmd(3'd1, 3'd5, '0, 0, 1'b0);            // READ_SNAP 5 -> 6
    do_cmd(3'd0, 3'd3, '0, 4, 1'b0);            // 4-cycle response stall
    do_cmd(3'd4, 3'd0, 32'h0, 1, 1'b1);         // reset while response pending

    // CLEAR whose EXEC cycle sees reset must not strobe
    cmd_valid_i = 1'b1;
    cmd_op_i    = 3'd3;
    cmd_idx_i   = 3'd0;
    cmd_wdata_i = 32'h3F;
    check("clrrst_ready", 64'(cmd_ready_o), 64'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check("clrrst_no_strobe", 64'(cnt_clr_o), 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    model_reset();
    check("clrrst_no_rsp", 64'(rsp_valid_o), 64'd0);
    check("clrrst_idle", 64'(cmd_ready_o), 64'd1);

    // Random commands
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < NUM; k++) cur_vals[k] = $urandom;
      r_op  = 3'($urandom_range(0, 7));
      r_idx = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      do_cmd(r_op, r_idx, $urandom, $urandom_range(0, 3), 1'b0);
    end

    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
